// File: rtl/clk_rate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_rate_pkg
//  Description : Shared types and the saturating step helper for the
//                run-time clock-rate controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_rate_pkg;

    // Arithmetic width for step/clamp math; one bit wider than the widest
    // supported period so up-steps can never wrap before saturation.
    localparam int unsigned c_CALC_W = 65;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    // Move value by step in the given direction, then clamp to [min_v, max_v].
    // With step=0 this is a plain clamp, which is how the load path uses it.
    function automatic logic [c_CALC_W-1:0] sat_step(
        input logic [c_CALC_W-1:0] value,
        input dir_t                dir,
        input logic [c_CALC_W-1:0] step,
        input logic [c_CALC_W-1:0] min_v,
        input logic [c_CALC_W-1:0] max_v
    );
        logic [c_CALC_W-1:0] w_res;
        if (dir == DIR_UP) begin
            w_res = value + step;
        end else if (value >= step) begin
            w_res = value - step;
        end else begin
            w_res = '0;
        end
        if (w_res < min_v) begin
            w_res = min_v;
        end
        if (w_res > max_v) begin
            w_res = max_v;
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_rate_div.sv
`default_nettype none
// ============================================================================
//  Module      : clk_rate_div
//  Description : Variable-period divider. The period is shadowed from target
//                only at a wrap so every half-phase runs at the length it
//                started with.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_rate_div #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned INIT_PERIOD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] period,
    output logic             clkout,
    output logic             tick
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period;
    logic             r_clkout;
    logic             r_tick;

    // Down-counter: at zero reload from target, latch it as the active period and toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_period <= WIDTH'(INIT_PERIOD);
            r_clkout <= 1'b0;
            r_tick   <= 1'b0;
        end else if (r_count == '0) begin
            r_count  <= target - WIDTH'(1);
            r_period <= target;
            r_clkout <= ~r_clkout;
            r_tick   <= 1'b1;
        end else begin
            r_count  <= r_count - WIDTH'(1);
            r_tick   <= 1'b0;
        end
    end

    assign period = r_period;
    assign clkout = r_clkout;
    assign tick   = r_tick;

endmodule
`default_nettype wire

// File: rtl/clk_rate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clk_rate_ctrl
//  Description : Button/load driven period controller with hold-to-repeat,
//                feeding a glitch-free variable-period divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_rate_ctrl
    import clk_rate_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned INIT_PERIOD   = 4,
    parameter int unsigned MIN_PERIOD    = 2,
    parameter int unsigned MAX_PERIOD    = 8,
    parameter int unsigned STEP          = 1,
    parameter int unsigned HOLD_CYCLES   = 10,
    parameter int unsigned REPEAT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] period,
    output logic             pending,
    output logic             clkout,
    output logic             tick
);

    localparam int unsigned c_TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned c_TMR_W   = $clog2(c_TMR_MAX);
    localparam logic [c_TMR_W-1:0]  c_HOLD_LD = c_TMR_W'(HOLD_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]  c_REP_LD  = c_TMR_W'(REPEAT_CYCLES - 1);
    localparam logic [c_CALC_W-1:0] c_STEP    = c_CALC_W'(STEP);
    localparam logic [c_CALC_W-1:0] c_MIN     = c_CALC_W'(MIN_PERIOD);
    localparam logic [c_CALC_W-1:0] c_MAX     = c_CALC_W'(MAX_PERIOD);

    state_t             r_state, w_state_nxt;
    dir_t               r_dir, w_dir_nxt, w_step_dir;
    logic [c_TMR_W-1:0] r_timer, w_timer_nxt;
    logic               r_up_d, r_dn_d;
    logic [WIDTH-1:0]   r_target;
    logic               w_step;

    // A request is valid only when exactly one button is pressed.
    logic w_up_req, w_dn_req, w_up_rise, w_dn_rise, w_req_held;
    assign w_up_req   = btn_up & ~btn_dn;
    assign w_dn_req   = btn_dn & ~btn_up;
    assign w_up_rise  = w_up_req & ~r_up_d;
    assign w_dn_rise  = w_dn_req & ~r_dn_d;
    assign w_req_held = (r_dir == DIR_UP) ? w_up_req : w_dn_req;

    logic [WIDTH-1:0] w_step_val, w_load_val;
    assign w_step_val = WIDTH'(sat_step(c_CALC_W'(r_target), w_step_dir, c_STEP, c_MIN, c_MAX));
    assign w_load_val = WIDTH'(sat_step(c_CALC_W'(load_value), DIR_UP, '0, c_MIN, c_MAX));

    // Press/hold/repeat sequencing: decides when a step happens and in which direction.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_timer_nxt = r_timer;
        w_step      = 1'b0;
        w_step_dir  = r_dir;
        case (r_state)
            IDLE: begin
                if (w_up_rise) begin
                    w_step      = 1'b1;
                    w_step_dir  = DIR_UP;
                    w_dir_nxt   = DIR_UP;
                    w_timer_nxt = c_HOLD_LD;
                    w_state_nxt = HOLD;
                end else if (w_dn_rise) begin
                    w_step      = 1'b1;
                    w_step_dir  = DIR_DN;
                    w_dir_nxt   = DIR_DN;
                    w_timer_nxt = c_HOLD_LD;
                    w_state_nxt = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (!w_req_held) begin
                    w_state_nxt = IDLE;
                end else if (r_timer == '0) begin
                    w_step      = 1'b1;
                    w_timer_nxt = c_REP_LD;
                    w_state_nxt = REPEAT;
                end else begin
                    w_timer_nxt = r_timer - c_TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM, timer and request-history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_dir   <= DIR_UP;
            r_timer <= '0;
            r_up_d  <= 1'b0;
            r_dn_d  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_timer <= w_timer_nxt;
            r_up_d  <= w_up_req;
            r_dn_d  <= w_dn_req;
        end
    end

    // Target register: a load wins over a step in the same cycle, and that step is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target <= WIDTH'(INIT_PERIOD);
        end else if (load) begin
            r_target <= w_load_val;
        end else if (w_step) begin
            r_target <= w_step_val;
        end
    end

    clk_rate_div #(
        .WIDTH       (WIDTH),
        .INIT_PERIOD (INIT_PERIOD)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .target (r_target),
        .period (period),
        .clkout (clkout),
        .tick   (tick)
    );

    assign pending = (r_target != period);

endmodule
`default_nettype wire

// File: tb/tb_clk_rate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_rate_ctrl
//  Description : Directed self-checking bench for clk_rate_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_rate_ctrl;
    import clk_rate_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        btn_up = 1'b0;
    logic        btn_dn = 1'b0;
    logic        load = 1'b0;
    logic [31:0] load_value = '0;
    logic [31:0] period;
    logic        pending;
    logic        clkout;
    logic        tick;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clk_rate_ctrl #(
        .WIDTH         (32),
        .INIT_PERIOD   (4),
        .MIN_PERIOD    (2),
        .MAX_PERIOD    (8),
        .STEP          (1),
        .HOLD_CYCLES   (10),
        .REPEAT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up     (btn_up),
        .btn_dn     (btn_dn),
        .load       (load),
        .load_value (load_value),
        .period     (period),
        .pending    (pending),
        .clkout     (clkout),
        .tick       (tick)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Free run at period 4 right after reset release: toggles on edges 1,5,9,...
    task automatic check_free_run(input string pfx);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check_val({pfx, "_clkout"}, 32'(clkout), 32'((((k - 1) / 4) % 2) == 0));
            check_val({pfx, "_tick"},   32'(tick),   32'((k % 4) == 1));
            check_val({pfx, "_period"}, period, 32'd4);
            check_val({pfx, "_pending"}, 32'(pending), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;

        // ---- Scenario 1: reset and free run
        #1 rst_n = 1'b0;
        step(2);
        check_val("rst_clkout",  32'(clkout),  32'd0);
        check_val("rst_tick",    32'(tick),    32'd0);
        check_val("rst_period",  period,       32'd4);
        check_val("rst_pending", 32'(pending), 32'd0);
        rst_n = 1'b1;
        check_free_run("s1");

        // ---- Scenario 2: short up press mid half-phase (now after edge 12)
        step(2);                                   // edge 14
        btn_up = 1'b1;
        step(1);                                   // edge 15
        check_val("s2_target",  dut.r_target, 32'd5);
        check_val("s2_pend1",   32'(pending), 32'd1);
        check_val("s2_period4", period,       32'd4);
        step(1);                                   // edge 16
        check_val("s2_pend2",   32'(pending), 32'd1);
        step(1);                                   // edge 17: wrap after a 4-cycle half-phase
        check_val("s2_period5", period,       32'd5);
        check_val("s2_pend0",   32'(pending), 32'd0);
        check_val("s2_tick17",  32'(tick),    32'd1);
        check_val("s2_clk17",   32'(clkout),  32'd1);
        btn_up = 1'b0;
        step(1);                                   // edge 18
        check_val("s2_idle",    32'(dut.r_state), 32'(IDLE));
        step(3);                                   // edge 21
        check_val("s2_tick21",  32'(tick),    32'd0);
        step(1);                                   // edge 22
        check_val("s2_tick22",  32'(tick),    32'd1);
        check_val("s2_clk22",   32'(clkout),  32'd0);

        // ---- Scenario 3: hold up from 4 with auto-repeat to saturation
        load = 1'b1; load_value = 32'd4;
        step(1);
        load = 1'b0;
        check_val("s3_load4", dut.r_target, 32'd4);
        btn_up = 1'b1;
        step(1);  check_val("s3_p0",  dut.r_target, 32'd5);
        step(9);  check_val("s3_p9",  dut.r_target, 32'd5);
        step(1);  check_val("s3_p10", dut.r_target, 32'd6);
        step(3);  check_val("s3_p13", dut.r_target, 32'd6);
        step(1);  check_val("s3_p14", dut.r_target, 32'd7);
        step(4);  check_val("s3_p18", dut.r_target, 32'd8);
        step(4);  check_val("s3_p22", dut.r_target, 32'd8);
        step(7);  check_val("s3_p29", dut.r_target, 32'd8);
        check_val("s3_rep", 32'(dut.r_state), 32'(REPEAT));
        btn_up = 1'b0;
        step(1);  check_val("s3_idle", 32'(dut.r_state), 32'(IDLE));

        // ---- Scenario 4: hold down to saturation, then load clamps
        btn_dn = 1'b1;
        step(1);  check_val("s4_q0",  dut.r_target, 32'd7);
        step(25); check_val("s4_q25", dut.r_target, 32'd3);
        step(1);  check_val("s4_q26", dut.r_target, 32'd2);
        step(8);  check_val("s4_q34", dut.r_target, 32'd2);
        btn_dn = 1'b0;
        step(2);
        load = 1'b1; load_value = 32'd1;
        step(1);  check_val("s4_ld1",   dut.r_target, 32'd2);
        load_value = 32'd100;
        step(1);  check_val("s4_ld100", dut.r_target, 32'd8);
        load_value = 32'd3; btn_dn = 1'b1;
        step(1);  check_val("s4_ldpress", dut.r_target, 32'd3);
        check_val("s4_hold", 32'(dut.r_state), 32'(HOLD));
        load = 1'b0; btn_dn = 1'b0;
        step(2);

        // ---- Scenario 5: opposite button cancels, its release re-arms
        btn_up = 1'b1;
        step(1);  check_val("s5_a0",  dut.r_target, 32'd4);
        step(4);
        btn_dn = 1'b1;
        step(1);  check_val("s5_a5",  dut.r_target, 32'd4);
        check_val("s5_idle", 32'(dut.r_state), 32'(IDLE));
        step(9);  check_val("s5_a14", dut.r_target, 32'd4);
        btn_dn = 1'b0;
        step(1);  check_val("s5_a15", dut.r_target, 32'd5);
        check_val("s5_rehold", 32'(dut.r_state), 32'(HOLD));
        btn_up = 1'b0;
        step(2);

        // ---- Scenario 6: reset during REPEAT with period 7 and an update pending
        btn_up = 1'b1; load = 1'b1; load_value = 32'd7;
        step(20);
        load = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            step(1);
            if (dut.r_state == REPEAT && period == 32'd7 && pending) ok = 1'b1;
        end
        check_val("s6_setup", 32'(ok), 32'd1);
        rst_n = 1'b0; btn_up = 1'b0;
        #2;
        check_val("s6_clkout",  32'(clkout),  32'd0);
        check_val("s6_tick",    32'(tick),    32'd0);
        check_val("s6_period",  period,       32'd4);
        check_val("s6_pending", 32'(pending), 32'd0);
        check_val("s6_state",   32'(dut.r_state), 32'(IDLE));
        step(2);
        check_val("s6_clkout_hold", 32'(clkout), 32'd0);
        rst_n = 1'b1;
        check_free_run("s6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_rate_ctrl.md
Name: clk_rate_ctrl

Overview:
Run-time controller for the variable-period clock divider. Two debounced buttons (level inputs) step the divider period up or down, with hold-to-auto-repeat. A direct load port also sets the period. The new period is applied only at a divider wrap, so clkout never glitches or truncates a phase. Sits between the button debouncers and the LED/strobe logic that consumes clkout and tick.

Parameters:
WIDTH, 32, period/counter width
INIT_PERIOD, 4, period after reset (cycles per clkout half-phase)
MIN_PERIOD, 2, lower saturation bound (>=1)
MAX_PERIOD, 8, upper saturation bound (<= 2^WIDTH-1)
STEP, 1, increment/decrement per step
HOLD_CYCLES, 10, hold time before auto-repeat starts (>=2)
REPEAT_CYCLES, 4, auto-repeat interval (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_up  in  1  debounced level, 1 = pressed
btn_dn  in  1  debounced level, 1 = pressed
load  in  1  single-cycle strobe, load target from load_value
load_value  in  WIDTH  requested period, clamped to [MIN_PERIOD, MAX_PERIOD]
period  out  WIDTH  period currently used by the divider
pending  out  1  1 while target != period (update waiting for wrap)
clkout  out  1  divided clock, half-phase = period cycles
tick  out  1  one-cycle pulse, coincident with each clkout toggle

Behaviour:
- Reset (async assert, sync release): count=0, clkout=0, tick=0, period=INIT_PERIOD, target=INIT_PERIOD, pending=0, FSM=IDLE, repeat timer=0. rst_n low mid-operation aborts everything immediately. Nothing remembers a press across reset.
- Divider, each posedge clk:
  - if count==0: count<=target-1, period<=target, clkout<=~clkout, tick<=1.
  - else: count<=count-1, tick<=0.
  - First edge after reset release toggles clkout to 1.
  - pending is combinational: (target != period).
- Press qualification: up_req = btn_up & ~btn_dn; dn_req = btn_dn & ~btn_up. If both are pressed, neither request is active.
- Step rule: compute in WIDTH+1 bits.
  - up: target <= min(target+STEP, MAX_PERIOD)
  - dn: target <= max(target-STEP, MIN_PERIOD), with no underflow
  - A step at a bound is a no-op, not an error.
- FSM (state stored with the latched direction dir):
  - IDLE: on rising of up_req or dn_req: step once, latch dir, timer<=HOLD_CYCLES-1, go HOLD.
  - HOLD: if the latched request drops (release, or other button pressed) go IDLE. Else if timer==0: step, timer<=REPEAT_CYCLES-1, go REPEAT. Else timer--.
  - REPEAT: same release rule. If timer==0: step, reload REPEAT_CYCLES-1. Else timer--.
- load: target <= clamp(load_value) and has priority over any step in the same cycle. The suppressed step is lost. FSM state and timer still advance normally.
- Target change on the same edge as count==0: the divider uses the old target. The new value applies at the next wrap, one full half-phase later.
- clkout period = 2*period cycles. Duty cycle is 50% except across a period change, where each half-phase still completes at the length it started with.

Decomposition:
- Package clk_rate_pkg holds:
  - state enum {IDLE, HOLD, REPEAT}
  - direction enum {DIR_UP, DIR_DN}
  - a saturating step function (value, dir, step, min, max), which is reused by the load clamp.
- Sub-module clk_rate_div: counter, shadow period, clkout, tick. Inputs: clk, rst_n, target. Outputs: period, clkout, tick.
- Top clk_rate_ctrl: edge detect, FSM, timer, target register, load mux.

Test Plan:
1. Release reset with default parameters, no buttons. Required: clkout rises on the first edge, then toggles every 4 cycles; tick pulses each toggle; period=4; pending=0.
2. Pulse btn_up for 3 cycles mid half-phase. Required: target=5 next cycle and pending=1 until the next count==0. Then period=5, pending=0, and clkout toggles every 5 cycles; the half-phase in progress still lasts 4.
3. Hold btn_up for 30 cycles from period 4. Required: target steps 5 (press edge), 6 (+10 cycles), 7 (+14), 8 (+18), then stays at 8 (no overflow); FSM returns to IDLE one cycle after release.
4. Hold btn_dn from 8 until saturation. Required: target ends at 2, never 1 or wrapped. Then load=1 with load_value=1 gives target=2; load_value=100 gives target=8; load in the same cycle as a press edge shows the load value, not a step.
5. Hold btn_up, then press btn_dn at cycle 5, release btn_dn at cycle 15. Required: no step while both are pressed. FSM goes to IDLE at cycle 5; btn_dn release creates a rising up_req, giving one step and re-entering HOLD.
6. Drive rst_n low for 2 cycles during REPEAT with period=7 and pending=1. Required: all outputs are at reset values immediately while rst_n is low; after release, behaviour is identical to scenario 1.
